merge8to16_sorter: RTL and testbench
====================================

Name: merge8to16_sorter

Overview:
- Merges two ascending-sorted lists of 8 unsigned WIDTH-bit keys into one ascending-sorted list of 16 keys.
- Core is a Batcher odd-even merge network of compare-exchange cells.
- Building block of the V2V sorter datapath; feeds wider merge stages or the final sorted-output register.
- Output is registered: 1-cycle latency with a valid flag.

Parameters:
- WIDTH, 3, bit width of each unsigned key.
- N, 8, elements per input list; fixed at 8 (network topology is hard-wired for 8+8 -> 16).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  a/b carry a merge request this cycle.
- a  input  N*WIDTH  list A; element k (k=1..8) at bits [k*WIDTH-1:(k-1)*WIDTH]; ascending with k (a1 smallest).
- b  input  N*WIDTH  list B; same packing and ordering as a.
- out_valid  output  1  c holds a merge result.
- c  output  2*N*WIDTH  merged list; element k (k=1..16) at bits [k*WIDTH-1:(k-1)*WIDTH]; c1 (LSB slot) smallest, c16 largest.

Behaviour:
- Precondition: a1<=a2<=...<=a8 and b1<=...<=b8, unsigned compare. Correctness is checked only for sorted inputs. Unsorted inputs produce the deterministic output of the fixed network; no flag is raised.
- Compare-exchange cell: lower output = min(x,y), upper output = max(x,y), unsigned. On equality, values pass straight through, which is indistinguishable by value.
- Network: standard Batcher odd-even merge for 16 keys, built recursively:
  - odd-indexed elements of A and B merged by an 8-key odd-even merge;
  - even-indexed elements merged likewise;
  - final compare-exchange rank on adjacent interior pairs.
  - Depth 4 comparator ranks, 25 comparators total.
- The network is purely combinational between the input ports and the output register.
- Registering: on each rising clk:
  - rst=1: c <= 0 and out_valid <= 0.
  - otherwise: out_valid <= in_valid.
  - if in_valid=1: c <= network(a,b); if in_valid=0: c holds its previous value.
- Latency: exactly 1 cycle from in_valid/a/b sampled to c/out_valid.
- Throughput: one merge per cycle; back-to-back in_valid is fully supported. There is no backpressure and no ready signal.
- Reset priority: rst overrides in_valid in the same cycle. A request presented during reset is discarded, and out_valid stays 0 the following cycle.
- Reset mid-stream: the result in flight is dropped; the first valid output after rst deasserts corresponds to the first in_valid sampled with rst=0.
- Boundaries:
  - All keys equal: every output equals that key.
  - All A < all B: c = a1..a8 then b1..b8.
  - Keys 0 and 2^WIDTH-1 handled with no overflow, because only comparisons are performed and there is no arithmetic.
- Output is a permutation of the 16 input keys; no key is duplicated or lost.

Test Plan:
- Reset: assert rst 2 cycles with in_valid=1 and arbitrary a/b -> c=0, out_valid=0 throughout and one cycle after release.
- Saturated A (WIDTH=3): a=7,7,7,7,7,7,7,7; b=1,3,4,6,7,7,7,7; in_valid=1 -> next cycle out_valid=1, c1..c16 = 1,3,4,6,7,7,7,7,7,7,7,7,7,7,7,7.
- Interleave: a=0,2,2,4,4,6,6,7; b=1,1,3,3,5,5,6,7 -> c = 0,1,1,2,2,3,3,4,4,5,5,6,6,6,7,7.
- Disjoint ranges: a=0,0,1,1,2,2,3,3; b=4,4,5,5,6,6,7,7 -> c = a then b. Swap a and b -> same c.
- Back-to-back plus hold: three consecutive valid requests, then in_valid=0 -> three consecutive correct results each 1 cycle late, then out_valid=0 with c holding the third result.
- Random regression: 1000 random sorted a/b pairs with random in_valid gaps and occasional rst pulses -> c equals the sorted concatenation of a and b, compared one cycle later by a scoreboard.

Source files
------------

// File: rtl/merge8to16_sorter.sv
// Merges two ascending 8-key lists into one ascending 16-key list through a Batcher odd-even merge network.
// Result is registered one cycle after in_valid; one merge per cycle, with no backpressure.
module merge8to16_sorter #(
    parameter int WIDTH = 3,
    parameter int N     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N*WIDTH-1:0]     a,
    input  logic [N*WIDTH-1:0]     b,
    output logic                   out_valid,
    output logic [2*N*WIDTH-1:0]   c
);

    localparam int M = 2 * N;

    logic [WIDTH-1:0]     w_key [M];
    logic [WIDTH-1:0]     w_tmp;
    logic [M*WIDTH-1:0]   w_net;
    logic [M*WIDTH-1:0]   r_c;
    logic                 r_vld;

    // Ranks of stride N, N/2, ..., 1; both halves are already sorted,
    // so only the final merge stage of Batcher's sort is needed.
    always_comb begin
        w_tmp = '0;
        w_net = '0;
        for (int i = 0; i < N; i++) begin
            w_key[i]     = a[i*WIDTH +: WIDTH];
            w_key[i + N] = b[i*WIDTH +: WIDTH];
        end
        for (int k = N; k >= 1; k = k / 2) begin
            for (int j = k % N; j + k < M; j = j + 2 * k) begin
                for (int i = 0; i < k; i++) begin
                    if (w_key[i + j] > w_key[i + j + k]) begin
                        w_tmp              = w_key[i + j];
                        w_key[i + j]       = w_key[i + j + k];
                        w_key[i + j + k]   = w_tmp;
                    end
                end
            end
        end
        for (int i = 0; i < M; i++) begin
            w_net[i*WIDTH +: WIDTH] = w_key[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c   <= '0;
            r_vld <= 1'b0;
        end else begin
            r_vld <= in_valid;
            if (in_valid) begin
                r_c <= w_net;
            end
        end
    end

    assign c         = r_c;
    assign out_valid = r_vld;

endmodule

// File: tb/tb_merge8to16_sorter.sv
// Directed and random checks of merge8to16_sorter against a sort-based reference.
module tb_merge8to16_sorter;

    localparam int WIDTH = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [23:0]   a;
    logic [23:0]   b;
    logic          out_valid;
    logic [47:0]   c;

    int            n_cmp = 0;
    int            n_err = 0;
    logic          e_vld;
    logic [47:0]   e_c;
    logic [47:0]   third;

    merge8to16_sorter #(.WIDTH(WIDTH), .N(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .c         (c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] pk8(input int e1, input int e2, input int e3, input int e4,
                                        input int e5, input int e6, input int e7, input int e8);
        logic [23:0] r;
        r = '0;
        r[2:0]   = 3'(e1);
        r[5:3]   = 3'(e2);
        r[8:6]   = 3'(e3);
        r[11:9]  = 3'(e4);
        r[14:12] = 3'(e5);
        r[17:15] = 3'(e6);
        r[20:18] = 3'(e7);
        r[23:21] = 3'(e8);
        return r;
    endfunction

    // Reference: plain insertion sort of all 16 keys.
    function automatic logic [47:0] ref_merge(input logic [23:0] x, input logic [23:0] y);
        int v[16];
        int t;
        logic [47:0] r;
        for (int i = 0; i < 8; i++) begin
            v[i]     = int'(x[i*3 +: 3]);
            v[i + 8] = int'(y[i*3 +: 3]);
        end
        for (int i = 1; i < 16; i++) begin
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        end
        r = '0;
        for (int i = 0; i < 16; i++) r[i*3 +: 3] = 3'(v[i]);
        return r;
    endfunction

    function automatic logic [23:0] rand_sorted();
        int v[8];
        int t;
        logic [23:0] r;
        for (int i = 0; i < 8; i++) v[i] = int'($urandom_range(0, 7));
        for (int i = 1; i < 8; i++) begin
            for (int j = i; j > 0 && v[j-1] > v[j]; j--) begin
                t = v[j]; v[j] = v[j-1]; v[j-1] = t;
            end
        end
        r = '0;
        for (int i = 0; i < 8; i++) r[i*3 +: 3] = 3'(v[i]);
        return r;
    endfunction

    // Drive one cycle of inputs, advance past the edge, check against the register model.
    task automatic cycle(input string tag, input logic r, input logic v,
                         input logic [23:0] xa, input logic [23:0] xb);
        rst      = r;
        in_valid = v;
        a        = xa;
        b        = xb;
        if (r) begin
            e_vld = 1'b0;
            e_c   = '0;
        end else begin
            e_vld = v;
            if (v) e_c = ref_merge(xa, xb);
        end
        @(posedge clk);
        #1;
        chk({tag, "_vld"}, {47'd0, out_valid}, {47'd0, e_vld});
        chk({tag, "_c"}, c, e_c);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b1; a = '0; b = '0;
        e_vld = 1'b0; e_c = '0; third = '0;

        // Reset with a live request: discarded, outputs stay zero.
        cycle("rst0", 1'b1, 1'b1, pk8(1,2,3,4,5,6,7,7), pk8(0,0,1,1,2,2,3,3));
        chk("rst0_c_zero", c, 48'd0);
        cycle("rst1", 1'b1, 1'b1, pk8(0,1,2,3,4,5,6,7), pk8(7,7,7,7,7,7,7,7));
        chk("rst1_c_zero", c, 48'd0);
        cycle("rel", 1'b0, 1'b0, '0, '0);
        chk("rel_c_zero", c, 48'd0);

        cycle("sat", 1'b0, 1'b1, pk8(7,7,7,7,7,7,7,7), pk8(1,3,4,6,7,7,7,7));
        chk("sat_hand", c, {pk8(7,7,7,7,7,7,7,7), pk8(1,3,4,6,7,7,7,7)});

        cycle("ilv", 1'b0, 1'b1, pk8(0,2,2,4,4,6,6,7), pk8(1,1,3,3,5,5,6,7));
        chk("ilv_hand", c, {pk8(4,5,5,6,6,6,7,7), pk8(0,1,1,2,2,3,3,4)});

        cycle("dsj", 1'b0, 1'b1, pk8(0,0,1,1,2,2,3,3), pk8(4,4,5,5,6,6,7,7));
        chk("dsj_hand", c, {pk8(4,4,5,5,6,6,7,7), pk8(0,0,1,1,2,2,3,3)});
        cycle("dsw", 1'b0, 1'b1, pk8(4,4,5,5,6,6,7,7), pk8(0,0,1,1,2,2,3,3));
        chk("dsw_hand", c, {pk8(4,4,5,5,6,6,7,7), pk8(0,0,1,1,2,2,3,3)});

        cycle("eq", 1'b0, 1'b1, pk8(5,5,5,5,5,5,5,5), pk8(5,5,5,5,5,5,5,5));
        chk("eq_hand", c, {pk8(5,5,5,5,5,5,5,5), pk8(5,5,5,5,5,5,5,5)});

        // Three back-to-back requests, then idle: c must hold the third result.
        cycle("b2b0", 1'b0, 1'b1, pk8(0,1,2,3,4,5,6,7), pk8(0,1,2,3,4,5,6,7));
        chk("b2b0_hand", c, {pk8(4,4,5,5,6,6,7,7), pk8(0,0,1,1,2,2,3,3)});
        cycle("b2b1", 1'b0, 1'b1, pk8(0,0,0,0,0,0,0,0), pk8(7,7,7,7,7,7,7,7));
        chk("b2b1_hand", c, {pk8(7,7,7,7,7,7,7,7), pk8(0,0,0,0,0,0,0,0)});
        cycle("b2b2", 1'b0, 1'b1, pk8(1,1,2,3,5,6,6,7), pk8(0,2,3,3,4,4,7,7));
        third = {pk8(4,4,5,6,6,7,7,7), pk8(0,1,1,2,2,3,3,3)};
        chk("b2b2_hand", c, third);
        cycle("hold0", 1'b0, 1'b0, pk8(0,0,0,0,0,0,0,0), pk8(0,0,0,0,0,0,0,0));
        chk("hold0_hand", c, third);
        cycle("hold1", 1'b0, 1'b0, pk8(7,7,7,7,7,7,7,7), pk8(0,0,0,0,0,0,0,0));
        chk("hold1_hand", c, third);

        // Random sorted pairs with idle gaps and occasional reset pulses.
        for (int n = 0; n < 1000; n++) begin
            cycle("rnd", ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 70),
                  rand_sorted(), rand_sorted());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
